// File: rtl/tankb_pkg.sv
// Shared definitions for the tank-battle video subsystem: VRAM geometry,
// arbiter state encoding and video fetch latency bounds.
package tankb_pkg;

  localparam int VRAM_AW     = 11;
  localparam int VRAM_DW     = 8;
  localparam int VID_LAT_MIN = 3;
  localparam int VID_LAT_MAX = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    VID_RD  = 3'd1,
    VID_CAP = 3'd2,
    CPU_RD  = 3'd3,
    CPU_CAP = 3'd4,
    CPU_WR  = 3'd5
  } vram_arb_state_t;

endpackage

// File: rtl/vram_arbiter_if.sv
// Signal bundle between the arbiter, its two requesters and the single-port VRAM.
interface vram_arbiter_if
  import tankb_pkg::*;
#(
  parameter int AW = VRAM_AW,
  parameter int DW = VRAM_DW
);
  logic          vid_req;
  logic [AW-1:0] vid_addr;
  logic [DW-1:0] vid_data;
  logic          vid_valid;
  logic          vid_overrun;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_ack;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  modport slave (
    input  vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
    output vid_data, vid_valid, vid_overrun, cpu_rdata, cpu_ack,
           ram_addr, ram_we, ram_wdata
  );

  modport master (
    output vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
    input  vid_data, vid_valid, vid_overrun, cpu_rdata, cpu_ack,
           ram_addr, ram_we, ram_wdata
  );
endinterface

// File: rtl/vram_arbiter.sv
// Time-shares one synchronous single-port VRAM between video tile fetches
// (strict priority, bounded latency) and atomic 6502 CPU accesses.
module vram_arbiter
  import tankb_pkg::*;
#(
  parameter int AW = VRAM_AW,
  parameter int DW = VRAM_DW
) (
  input logic           clk,
  input logic           rst,
  vram_arbiter_if.slave bus
);

  vram_arb_state_t state, state_nxt;

  logic          vid_pend;
  logic [AW-1:0] vid_addr_lat;
  logic [AW-1:0] vid_addr_sel;
  logic          vid_go;
  logic          cpu_go;

  logic [DW-1:0] vid_data_r;
  logic          vid_valid_r;
  logic          vid_overrun_r;
  logic [DW-1:0] cpu_rdata_r;
  logic          cpu_ack_r;
  logic [AW-1:0] ram_addr_r;
  logic          ram_we_r;
  logic [DW-1:0] ram_wdata_r;

  // The request held during CPU_WR/CPU_CAP is the one being completed, so it
  // is masked there as well as during the ack cycle to avoid a second access.
  always_comb begin
    vid_go       = vid_pend || bus.vid_req;
    vid_addr_sel = vid_pend ? vid_addr_lat : bus.vid_addr;
    cpu_go       = bus.cpu_req && !cpu_ack_r &&
                   (state != CPU_WR) && (state != CPU_CAP);
    state_nxt    = IDLE;
    case (state)
      VID_RD:  state_nxt = VID_CAP;
      CPU_RD:  state_nxt = CPU_CAP;
      default: begin
        if (vid_go)                    state_nxt = VID_RD;
        else if (cpu_go && bus.cpu_we) state_nxt = CPU_WR;
        else if (cpu_go)               state_nxt = CPU_RD;
        else                           state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      vid_pend      <= 1'b0;
      vid_addr_lat  <= '0;
      vid_data_r    <= '0;
      vid_valid_r   <= 1'b0;
      vid_overrun_r <= 1'b0;
      cpu_rdata_r   <= '0;
      cpu_ack_r     <= 1'b0;
      ram_addr_r    <= '0;
      ram_we_r      <= 1'b0;
      ram_wdata_r   <= '0;
    end else begin
      state <= state_nxt;

      // A request seen with the latch already full is dropped; first address wins.
      if (state_nxt == VID_RD) begin
        vid_pend <= 1'b0;
      end else if (bus.vid_req && !vid_pend) begin
        vid_pend     <= 1'b1;
        vid_addr_lat <= bus.vid_addr;
      end
      if (bus.vid_req && vid_pend)
        vid_overrun_r <= 1'b1;

      // RAM port: registered from the state being entered.
      ram_we_r <= (state_nxt == CPU_WR);
      case (state_nxt)
        VID_RD: ram_addr_r <= vid_addr_sel;
        CPU_RD: ram_addr_r <= bus.cpu_addr;
        CPU_WR: begin
          ram_addr_r  <= bus.cpu_addr;
          ram_wdata_r <= bus.cpu_wdata;
        end
        default: ;
      endcase

      vid_valid_r <= (state == VID_CAP);
      if (state == VID_CAP)
        vid_data_r <= bus.ram_rdata;

      cpu_ack_r <= (state == CPU_CAP) || (state == CPU_WR);
      if (state == CPU_CAP)
        cpu_rdata_r <= bus.ram_rdata;
    end
  end

  assign bus.vid_data    = vid_data_r;
  assign bus.vid_valid   = vid_valid_r;
  assign bus.vid_overrun = vid_overrun_r;
  assign bus.cpu_rdata   = cpu_rdata_r;
  assign bus.cpu_ack     = cpu_ack_r;
  assign bus.ram_addr    = ram_addr_r;
  assign bus.ram_we      = ram_we_r;
  assign bus.ram_wdata   = ram_wdata_r;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural 2Kx8 synchronous RAM.
module tb_vram_arbiter;

  logic clk;
  logic rst;

  vram_arbiter_if #(.AW(11), .DW(8)) vif ();

  vram_arbiter #(.AW(11), .DW(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (vif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port RAM (read-first) with a bench preload port.
  logic [7:0]  mem [0:2047];
  logic        pre_we;
  logic [10:0] pre_addr;
  logic [7:0]  pre_data;

  always @(posedge clk) begin
    if (pre_we)
      mem[pre_addr] <= pre_data;
    else if (vif.ram_we)
      mem[vif.ram_addr] <= vif.ram_wdata;
    vif.ram_rdata <= mem[vif.ram_addr];
  end

  int we_cnt = 0;
  always @(negedge clk)
    if (vif.ram_we) we_cnt <= we_cnt + 1;

  int n_checks = 0;
  int n_errors = 0;
  int w0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [10:0] a, input logic [7:0] d);
    pre_we   = 1'b1;
    pre_addr = a;
    pre_data = d;
    step();
    pre_we   = 1'b0;
  endtask

  task automatic cpu_issue(input logic we, input logic [10:0] a, input logic [7:0] d);
    vif.cpu_req   = 1'b1;
    vif.cpu_we    = we;
    vif.cpu_addr  = a;
    vif.cpu_wdata = d;
  endtask

  initial begin
    rst           = 1'b1;
    vif.vid_req   = 1'b0;
    vif.vid_addr  = '0;
    vif.cpu_req   = 1'b0;
    vif.cpu_we    = 1'b0;
    vif.cpu_addr  = '0;
    vif.cpu_wdata = '0;
    pre_we        = 1'b0;
    pre_addr      = '0;
    pre_data      = '0;
    step();
    preload(11'h123, 8'hA5);
    preload(11'h010, 8'h11);
    preload(11'h020, 8'h22);
    preload(11'h050, 8'h55);
    preload(11'h060, 8'h66);
    preload(11'h070, 8'h77);
    step();

    chk("rst_vid_data",  vif.vid_data,    0);
    chk("rst_vid_valid", vif.vid_valid,   0);
    chk("rst_overrun",   vif.vid_overrun, 0);
    chk("rst_cpu_rdata", vif.cpu_rdata,   0);
    chk("rst_cpu_ack",   vif.cpu_ack,     0);
    chk("rst_ram_addr",  vif.ram_addr,    0);
    chk("rst_ram_we",    vif.ram_we,      0);
    chk("rst_ram_wdata", vif.ram_wdata,   0);
    rst = 1'b0;
    step();

    // Idle video fetch
    w0 = we_cnt;
    vif.vid_req  = 1'b1;
    vif.vid_addr = 11'h123;
    step();
    vif.vid_req = 1'b0;
    chk("t1_ram_addr", vif.ram_addr, 11'h123);
    chk("t1_ram_we",   vif.ram_we,   0);
    chk("t1_vv_t1",    vif.vid_valid, 0);
    step();
    chk("t1_vv_t2",    vif.vid_valid, 0);
    step();
    chk("t1_vv_t3",    vif.vid_valid, 1);
    chk("t1_vid_data", vif.vid_data,  8'hA5);
    step();
    chk("t1_vv_t4",    vif.vid_valid, 0);
    chk("t1_vid_hold", vif.vid_data,  8'hA5);
    chk("t1_no_we",    we_cnt - w0,   0);

    // CPU write then read; requester holds cpu_req through the ack cycle
    w0 = we_cnt;
    cpu_issue(1'b1, 11'h400, 8'h3C);
    step();
    chk("t2w_ram_we",    vif.ram_we,    1);
    chk("t2w_ram_addr",  vif.ram_addr,  11'h400);
    chk("t2w_ram_wdata", vif.ram_wdata, 8'h3C);
    chk("t2w_ack_t1",    vif.cpu_ack,   0);
    step();
    chk("t2w_ack_t2",    vif.cpu_ack,   1);
    chk("t2w_we_t2",     vif.ram_we,    0);
    step();
    vif.cpu_req = 1'b0;
    chk("t2w_ack_t3",    vif.cpu_ack,   0);
    step();
    chk("t2w_we_once",   we_cnt - w0,   1);

    cpu_issue(1'b0, 11'h400, 8'h00);
    step();
    chk("t2r_ram_addr", vif.ram_addr, 11'h400);
    chk("t2r_ram_we",   vif.ram_we,   0);
    chk("t2r_ack_t1",   vif.cpu_ack,  0);
    step();
    chk("t2r_ack_t2",   vif.cpu_ack,  0);
    step();
    chk("t2r_ack_t3",   vif.cpu_ack,  1);
    chk("t2r_rdata",    vif.cpu_rdata, 8'h3C);
    step();
    vif.cpu_req = 1'b0;
    chk("t2r_ack_t4",   vif.cpu_ack,  0);
    step();
    chk("t2r_ack_t5",   vif.cpu_ack,  0);
    step();

    // Collision in IDLE: video first, CPU read follows without a gap
    vif.vid_req  = 1'b1;
    vif.vid_addr = 11'h010;
    cpu_issue(1'b0, 11'h020, 8'h00);
    step();
    vif.vid_req = 1'b0;
    chk("t3_ram_addr_v", vif.ram_addr, 11'h010);
    step();
    step();
    chk("t3_vv_t3",      vif.vid_valid, 1);
    chk("t3_vid_data",   vif.vid_data,  8'h11);
    chk("t3_ram_addr_c", vif.ram_addr,  11'h020);
    step();
    chk("t3_vv_t4",      vif.vid_valid, 0);
    chk("t3_ack_t4",     vif.cpu_ack,   0);
    step();
    chk("t3_ack_t5",     vif.cpu_ack,   1);
    chk("t3_rdata",      vif.cpu_rdata, 8'h22);
    step();
    vif.cpu_req = 1'b0;
    chk("t3_ack_t6",     vif.cpu_ack,   0);
    step();

    // Video request arriving in CPU_RD: worst-case latency of 4
    cpu_issue(1'b0, 11'h050, 8'h00);
    step();
    vif.vid_req  = 1'b1;
    vif.vid_addr = 11'h060;
    step();
    vif.vid_req = 1'b0;
    step();
    chk("t4_ack",      vif.cpu_ack,   1);
    chk("t4_rdata",    vif.cpu_rdata, 8'h55);
    chk("t4_ram_addr", vif.ram_addr,  11'h060);
    step();
    vif.cpu_req = 1'b0;
    chk("t4_vv_t3",    vif.vid_valid, 0);
    step();
    chk("t4_vv_t4",    vif.vid_valid, 1);
    chk("t4_vid_data", vif.vid_data,  8'h66);
    chk("t4_rdata_keep", vif.cpu_rdata, 8'h55);
    step();

    // Overrun: second vid_req while the first is still pending
    cpu_issue(1'b0, 11'h020, 8'h00);
    step();
    vif.vid_req  = 1'b1;
    vif.vid_addr = 11'h070;
    step();
    vif.vid_addr = 11'h123;
    chk("t5_ovr_early", vif.vid_overrun, 0);
    step();
    vif.vid_req = 1'b0;
    chk("t5_ack",      vif.cpu_ack,     1);
    chk("t5_rdata",    vif.cpu_rdata,   8'h22);
    chk("t5_overrun",  vif.vid_overrun, 1);
    chk("t5_ram_addr", vif.ram_addr,    11'h070);
    step();
    vif.cpu_req = 1'b0;
    step();
    chk("t5_vv",       vif.vid_valid,   1);
    chk("t5_vid_data", vif.vid_data,    8'h77);
    step();
    chk("t5_vv_after1", vif.vid_valid,  0);
    step();
    chk("t5_vv_after2", vif.vid_valid,  0);
    step();
    chk("t5_vv_after3", vif.vid_valid,  0);
    chk("t5_ovr_sticky", vif.vid_overrun, 1);

    // Reset while in CPU_WR aborts the access
    cpu_issue(1'b1, 11'h200, 8'h99);
    step();
    chk("t6_we_before", vif.ram_we, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    vif.cpu_req = 1'b0;
    chk("t6_ack",       vif.cpu_ack,     0);
    chk("t6_ram_we",    vif.ram_we,      0);
    chk("t6_ram_addr",  vif.ram_addr,    0);
    chk("t6_ram_wdata", vif.ram_wdata,   0);
    chk("t6_overrun",   vif.vid_overrun, 0);
    chk("t6_vid_data",  vif.vid_data,    0);
    chk("t6_vid_valid", vif.vid_valid,   0);
    chk("t6_cpu_rdata", vif.cpu_rdata,   0);
    step();
    chk("t6_ack_late",  vif.cpu_ack,     0);
    cpu_issue(1'b0, 11'h123, 8'h00);
    step();
    step();
    step();
    chk("t6_next_ack",   vif.cpu_ack,   1);
    chk("t6_next_rdata", vif.cpu_rdata, 8'hA5);
    vif.cpu_req = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
